// File: rtl/mem_arbiter_pkg.sv
// Shared types and widths for the I/D cache memory arbiter.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W = 24;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              wr;
    } mem_req_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin choice: on a tie the requester not granted last wins.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last,
    output logic [1:0] gnt_c
);

    always_comb begin
        gnt_c = 2'b00;
        if (req == 2'b11) begin
            gnt_c = (last == OWN_D) ? 2'b01 : 2'b10;
        end else begin
            gnt_c = req;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache refills and D-cache line reads/write-backs onto one burst memory port.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned BEATS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_valid,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_wr,
    output logic              d_ready,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_wnext,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_valid,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_wr,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_wack,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata
);

    localparam int unsigned CNT_W = $clog2(BEATS);
    localparam int unsigned OFS_W = $clog2(BEATS) + 2;
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << OFS_W) - 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    state_t            state;
    state_t            state_nxt;
    owner_t            owner;
    owner_t            last_gnt;
    mem_req_t          req_q;
    logic [CNT_W-1:0]  beat_cnt;
    logic [1:0]        gnt_c;
    logic              beat_c;

    rr_arb2 u_rr (
        .req   ({d_valid, i_valid}),
        .last  (last_gnt),
        .gnt_c (gnt_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus the handshake and beat-routing strobes.
    always_comb begin
        state_nxt = state;
        i_ready   = 1'b0;
        d_ready   = 1'b0;
        i_rvalid  = 1'b0;
        d_rvalid  = 1'b0;
        d_wnext   = 1'b0;
        m_valid   = 1'b0;
        m_addr    = '0;
        m_wr      = 1'b0;
        m_wdata   = '0;
        beat_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|gnt_c) state_nxt = ST_REQ;
            end
            ST_REQ: begin
                m_valid = 1'b1;
                m_addr  = req_q.addr;
                m_wr    = req_q.wr;
                i_ready = m_ready && (owner == OWN_I);
                d_ready = m_ready && (owner == OWN_D);
                if (m_ready) state_nxt = ST_BURST;
            end
            ST_BURST: begin
                if (req_q.wr) begin
                    m_wdata = d_wdata;
                    d_wnext = m_wack;
                    beat_c  = m_wack;
                end else begin
                    beat_c   = m_rvalid;
                    i_rvalid = m_rvalid && (owner == OWN_I);
                    d_rvalid = m_rvalid && (owner == OWN_D);
                end
                if (beat_c && (beat_cnt == LAST_BEAT)) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

    // Owner/request capture in IDLE, history update on accept, beat counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner    <= OWN_I;
            last_gnt <= OWN_D;
            req_q    <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|gnt_c) begin
                        owner      <= gnt_c[1] ? OWN_D : OWN_I;
                        req_q.addr <= (gnt_c[1] ? d_addr : i_addr) & LINE_MASK;
                        req_q.wr   <= gnt_c[1] & d_wr;
                    end
                end
                ST_REQ: begin
                    if (m_ready) begin
                        beat_cnt <= '0;
                        last_gnt <= owner;
                    end
                end
                ST_BURST: begin
                    if (beat_c) begin
                        beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
